// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised raster timing generator with frame-aligned start/stop
// Optional colour-bar pattern generator built only when VIDEO_TPG_EN is defined.
module video_timing_gen #(
   parameter int   HDISP  = 800,
   parameter int   VDISP  = 480,
   parameter int   HFP    = 40,
   parameter int   HPULSE = 48,
   parameter int   HBP    = 40,
   parameter int   VFP    = 13,
   parameter int   VPULSE = 3,
   parameter int   VBP    = 29,
   parameter logic HS_POL = 1'b0,
   parameter logic VS_POL = 1'b0
) (
   input  logic        pixel_clk,
   input  logic        pixel_rst,
   input  logic        en,
   input  logic        tpg_en,
   input  logic [23:0] rgb_in,
   output logic [11:0] x,
   output logic [10:0] y,
   output logic        frame_start,
   output logic        line_start,
   output logic        hs,
   output logic        vs,
   output logic        blank_n,
   output logic [23:0] rgb_out,
   output logic        running
);

   localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
   localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;

   localparam logic [11:0] H_LAST = 12'(HTOTAL - 1);
   localparam logic [11:0] H_ACT  = 12'(HDISP);
   localparam logic [11:0] HS_BEG = 12'(HDISP + HFP);
   localparam logic [11:0] HS_END = 12'(HDISP + HFP + HPULSE);
   localparam logic [10:0] V_LAST = 11'(VTOTAL - 1);
   localparam logic [10:0] V_ACT  = 11'(VDISP);
   localparam logic [10:0] VS_BEG = 11'(VDISP + VFP);
   localparam logic [10:0] VS_END = 11'(VDISP + VFP + VPULSE);

   typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;

   state_t      state_q, state_d;
   logic [11:0] h_q, h_d;
   logic [10:0] v_q, v_d;
   logic        last_pix;
   logic        active;
   logic        hs_d, vs_d;
   logic [23:0] pix;
   logic [23:0] rgb_d;
   logic        hs_q, vs_q, blank_q;
   logic [23:0] rgb_q;

   assign last_pix = (h_q == H_LAST) && (v_q == V_LAST);

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A stop request only takes effect at the end of a complete frame.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (en) state_d = RUN;
         RUN:       if (!en) state_d = STOP_PEND;
         STOP_PEND: begin
            if (en) state_d = RUN;
            else if (last_pix) state_d = IDLE;
         end
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      running = (state_q != IDLE);
   end

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (!running) begin
         h_d = '0;
         v_d = '0;
      end else if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
      end else begin
         h_d = h_q + 12'd1;
      end
   end

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign x           = h_q;
   assign y           = v_q;
   assign line_start  = running && (h_q == '0);
   assign frame_start = line_start && (v_q == '0);

   assign active = running && (h_q < H_ACT) && (v_q < V_ACT);
   assign hs_d   = (running && (h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
   assign vs_d   = (running && (v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;

`ifdef VIDEO_TPG_EN
   logic [2:0]  bar_idx;
   logic [23:0] bar_rgb;

   assign bar_idx = 3'({h_q, 3'b000} / 15'(HDISP));

   always_comb begin
      bar_rgb = 24'h000000;
      case (bar_idx)
         3'd0:    bar_rgb = 24'hFFFFFF;
         3'd1:    bar_rgb = 24'hFFFF00;
         3'd2:    bar_rgb = 24'h00FFFF;
         3'd3:    bar_rgb = 24'h00FF00;
         3'd4:    bar_rgb = 24'hFF00FF;
         3'd5:    bar_rgb = 24'hFF0000;
         3'd6:    bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase
   end

   assign pix = tpg_en ? bar_rgb : rgb_in;
`else
   logic unused_tpg_en;

   assign unused_tpg_en = tpg_en;
   assign pix           = rgb_in;
`endif

   assign rgb_d = active ? pix : 24'h000000;

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         blank_q <= 1'b0;
         rgb_q   <= '0;
      end else begin
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         blank_q <= active;
         rgb_q   <= rgb_d;
      end
   end

   assign hs      = hs_q;
   assign vs      = vs_q;
   assign blank_n = blank_q;
   assign rgb_out = rgb_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized bench for video_timing_gen against a linear-position raster model
// Covers VIDEO_TPG_EN expectations when the macro is defined for the build.
module tb_video_timing_gen;

   localparam int HD = 160, VD = 90;
   localparam int HFP = 40, HP = 48, HBP = 40;
   localparam int VFP = 13, VP = 3, VBP = 29;
   localparam int HT = HD + HFP + HP + HBP;
   localparam int VT = VD + VFP + VP + VBP;
   localparam int FRAME = HT * VT;

   logic        pixel_clk = 1'b0;
   logic        pixel_rst = 1'b1;
   logic        en = 1'b0;
   logic        tpg_en = 1'b0;
   logic [23:0] rgb_in = '0;
   logic [11:0] x;
   logic [10:0] y;
   logic        frame_start, line_start, hs, vs, blank_n, running;
   logic [23:0] rgb_out;

   video_timing_gen #(.HDISP(HD), .VDISP(VD)) dut (
      .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .en(en), .tpg_en(tpg_en),
      .rgb_in(rgb_in), .x(x), .y(y), .frame_start(frame_start), .line_start(line_start),
      .hs(hs), .vs(vs), .blank_n(blank_n), .rgb_out(rgb_out), .running(running)
   );

   always #5 pixel_clk = ~pixel_clk;

   int      n_vec = 0;
   int      n_err = 0;
   longint  cyc = 0;
   longint  last_fs, last_ls;
   bit      rgb_mode = 0;

   // Model: run flag, stop request and the pixel's linear index inside the frame.
   bit          m_run, m_stop;
   int          m_p;
   bit          e_blank, e_hs, e_vs;
   logic [23:0] e_rgb;

   function automatic logic [23:0] bar_colour(int idx);
      case (idx)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic void model_reset();
      m_run = 0; m_stop = 0; m_p = 0;
      e_blank = 0; e_hs = 1; e_vs = 1; e_rgb = '0;
      last_fs = -1; last_ls = -1;
   endfunction

   function automatic void model_edge();
      int h, v;
      bit act;
      logic [23:0] pix;
      h = m_p % HT;
      v = m_p / HT;
      act = m_run && h < HD && v < VD;
      pix = rgb_in;
`ifdef VIDEO_TPG_EN
      if (tpg_en) pix = bar_colour(h * 8 / HD);
`endif
      e_blank = act;
      e_hs = !(m_run && h >= HD + HFP && h < HD + HFP + HP);
      e_vs = !(m_run && v >= VD + VFP && v < VD + VFP + VP);
      e_rgb = act ? pix : 24'h0;
      if (!m_run) begin
         if (en) begin m_run = 1; m_stop = 0; m_p = 0; end
      end else if (!en && m_stop && m_p == FRAME - 1) begin
         m_run = 0; m_stop = 0; m_p = 0;
      end else begin
         m_p = (m_p + 1) % FRAME;
         m_stop = !en;
      end
   endfunction

   task automatic cmp(string nm, int act, int exp);
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check();
      int ex, ey;
      ex = m_run ? m_p % HT : 0;
      ey = m_run ? m_p / HT : 0;
      n_vec++;
      cmp("x", int'(x), ex);
      cmp("y", int'(y), ey);
      cmp("frame_start", int'(frame_start), int'(m_run && m_p == 0));
      cmp("line_start", int'(line_start), int'(m_run && ex == 0));
      cmp("running", int'(running), int'(m_run));
      cmp("hs", int'(hs), int'(e_hs));
      cmp("vs", int'(vs), int'(e_vs));
      cmp("blank_n", int'(blank_n), int'(e_blank));
      cmp("rgb_out", int'(rgb_out), int'(e_rgb));
      if (line_start === 1'b1) begin
         if (last_ls >= 0) cmp("line_period", int'(cyc - last_ls), HT);
         last_ls = cyc;
      end
      if (frame_start === 1'b1) begin
         if (last_fs >= 0) cmp("frame_period", int'(cyc - last_fs), FRAME);
         last_fs = cyc;
      end
      if (running !== 1'b1) begin
         last_ls = -1;
         last_fs = -1;
      end
   endtask

   task automatic drive();
      int ex, ey;
      ex = m_run ? m_p % HT : 0;
      ey = m_run ? m_p / HT : 0;
      if (rgb_mode) rgb_in = {8'h00, 8'(ey), 8'(ex)};
      else rgb_in = 24'($urandom);
      tpg_en = 1'($urandom);
   endtask

   task automatic step();
      @(posedge pixel_clk);
      cyc++;
      if (pixel_rst) model_reset();
      else model_edge();
      @(negedge pixel_clk);
      check();
      drive();
   endtask

   task automatic run_to(int hx, int vy);
      int n;
      n = 0;
      while (!(m_run && m_p == vy * HT + hx) && n < FRAME + 10) begin
         step();
         n++;
      end
      if (!(m_run && m_p == vy * HT + hx)) begin
         n_err++;
         $display("FAIL run_to timeout: position (%0d,%0d) never reached", hx, vy);
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge pixel_clk);
      check();
      cmp("rst_x", int'(x), 0);
      cmp("rst_running", int'(running), 0);
      cmp("rst_hs", int'(hs), 1);
      cmp("rst_vs", int'(vs), 1);
      cmp("rst_blank_n", int'(blank_n), 0);
      cmp("rst_rgb_out", int'(rgb_out), 0);
      pixel_rst = 1'b0;
      repeat (3) step();

      en = 1'b1;
      step();
      cmp("start_x", int'(x), 0);
      cmp("start_y", int'(y), 0);
      cmp("start_frame_start", int'(frame_start), 1);
      cmp("start_running", int'(running), 1);
      rgb_mode = 1;

      run_to(200, 0);
      cmp("hs_before_pulse", int'(hs), 1);
      step();
      cmp("hs_pulse_first", int'(hs), 0);
      run_to(0, 1);
      cmp("blank_n_line_end", int'(blank_n), 0);
      step();
      cmp("blank_n_first_active", int'(blank_n), 1);
      run_to(160, 1);
      cmp("blank_n_last_active", int'(blank_n), 1);
      step();
      cmp("blank_n_after_active", int'(blank_n), 0);

      run_to(0, 20);
      rgb_mode = 0;
      run_to($urandom_range(0, HT - 1), 50);
      en = 1'b0;
      run_to($urandom_range(0, HT - 1), 80);
      en = 1'b1;
      run_to($urandom_range(0, HT - 1), 90);
      en = 1'b0;
      run_to(0, 103);
      cmp("vs_before_pulse", int'(vs), 1);
      step();
      cmp("vs_pulse_first", int'(vs), 0);
      run_to(HT - 1, VT - 1);
      cmp("stop_last_running", int'(running), 1);
      step();
      cmp("stop_running", int'(running), 0);
      cmp("stop_x", int'(x), 0);
      step();
      cmp("idle_blank_n", int'(blank_n), 0);
      cmp("idle_hs", int'(hs), 1);
      cmp("idle_vs", int'(vs), 1);
      cmp("idle_rgb_out", int'(rgb_out), 0);
      repeat ($urandom_range(5, 30)) step();

      en = 1'b1;
      rgb_mode = 1;
      step();
      run_to(100, 40);
      pixel_rst = 1'b1;
      #1;
      model_reset();
      check();
      cmp("midrst_x", int'(x), 0);
      cmp("midrst_running", int'(running), 0);
      cmp("midrst_blank_n", int'(blank_n), 0);
      repeat (2) step();
      pixel_rst = 1'b0;
      step();
      cmp("restart_x", int'(x), 0);
      cmp("restart_y", int'(y), 0);
      cmp("restart_frame_start", int'(frame_start), 1);

      rgb_mode = 0;
      run_to(0, $urandom_range(120, 133));
      en = 1'b0;
      run_to(HT - 1, VT - 1);
      en = 1'b1;
      step();
      cmp("nogap_frame_start", int'(frame_start), 1);
      cmp("nogap_running", int'(running), 1);
      repeat (300) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
